vend_panel_arbiter: RTL and testbench
=====================================

# vend_panel_arbiter

Round-robin session arbiter that shares the single vending core between `NUM_PANELS` customer front panels. A panel requests a session, and the arbiter grants exclusive ownership. It forwards only the owner's coin and selection strobes to the core, registered. It holds the grant until the core reports completion, the owner withdraws, or an inactivity timeout fires. The block sits between the panel front-ends and the `vending` core, inside the top-level wrapper.

## Interface
- `NUM_PANELS`, 4: number of requesting panels, 2..8.
- `COIN_W`, 2: coin code width.
- `SEL_W`, 2: product selection width.
- `TIMEOUT`, 255: idle cycles in a session before forced abort, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in `NUM_PANELS`: level request per panel. It must be held for the whole session.
- `panel_coin_valid` in `NUM_PANELS`: one-cycle coin strobe per panel.
- `panel_coin` in `NUM_PANELS*COIN_W`: packed coin codes, panel i at `[i*COIN_W +: COIN_W]`.
- `panel_sel_valid` in `NUM_PANELS`: one-cycle selection strobe per panel.
- `panel_sel` in `NUM_PANELS*SEL_W`: packed selections.
- `core_done` in 1: one-cycle pulse from the core when dispense and change are complete.
- `gnt` out `NUM_PANELS`: one-hot ownership, registered.
- `owner` out `$clog2(NUM_PANELS)`: index of the current or last owner.
- `core_coin_valid` / `core_coin` out 1 / `COIN_W`: forwarded owner coin.
- `core_sel_valid` / `core_sel` out 1 / `SEL_W`: forwarded owner selection.
- `abort` out 1: one-cycle pulse telling the core to refund and end the session.

## Operation
- **Reset values:**
  - `gnt`=0, `owner`=0, all `core_*`=0, `abort`=0.
  - State IDLE, timer 0.
  - Round-robin pointer set so panel 0 has highest priority.
- **States:** IDLE, ACTIVE, DRAIN, RELEASE.
- **IDLE:**
  - If any `req` bit is set, pick the first set bit searching from `last_owner+1`, wrapping modulo `NUM_PANELS`.
  - Load `gnt`/`owner`, clear the timer, and go to ACTIVE.
  - With no request, stay in IDLE.
- **ACTIVE:**
  - Forward `panel_*[owner]` to `core_*`. Strobes from non-owners are dropped silently.
  - The timer clears on any owner coin or selection strobe and increments otherwise.
  - `core_done` → RELEASE. This has highest priority.
  - Else owner `req` low, or timer == `TIMEOUT-1` → pulse `abort`, go to DRAIN.
- **DRAIN:**
  - `gnt` stays asserted and forwarding is disabled.
  - Wait for `core_done`, then go to RELEASE. There is no timeout in DRAIN.
- **RELEASE:**
  - `gnt`=0 for exactly one cycle (guard cycle).
  - `last_owner` ← `owner`, then go to IDLE.
- **Simultaneous events:**
  - `core_done` together with timeout or owner withdrawal: done wins, no `abort`.
  - An owner strobe in the same cycle as `core_done` or an abort decision is not forwarded.
- Requests arriving from other panels during a session are held by the requester and served in round-robin order afterwards. No starvation: after RELEASE, every requesting panel is granted within `NUM_PANELS` sessions.
- `owner` retains the last value after release.
- An asynchronous reset mid-session returns the block to reset values immediately. The core is reset by the same `rst`.

## Timing
- Request sampled in IDLE at cycle N → `gnt` high at N+1.
- Forwarding latency is 1 cycle: an owner strobe at cycle k → `core_*_valid` at k+1 with matching data. `core_*_valid` is never high for two consecutive cycles unless the inputs were.
- `core_done` at cycle k:
  - `gnt` low at k+1 (RELEASE).
  - IDLE at k+2.
  - Next `gnt` at k+3 at the earliest.
- Timeout: `TIMEOUT` cycles after the last owner strobe, or after the grant if no strobe occurred, `abort` pulses for 1 cycle.
- `gnt` is one-hot or zero at all times.
- `abort` fires at most once per session.

## Test plan
- **Single session:**
  - Stimulus: `req`=4'b0010; coin code 2 at grant+2; `sel`=1 at grant+4; `core_done` at grant+6.
  - Response: `gnt`=4'b0010 one cycle after `req`; `core_coin_valid` with coin 2 one cycle after the coin strobe; `gnt` low one cycle after done; `owner`=1.
- **Round robin:**
  - Stimulus: `req`=4'b1111 held; `core_done` each session.
  - Response: grant order 0,1,2,3,0; one RELEASE guard cycle with `gnt`=0 between each grant.
- **Isolation:**
  - Stimulus: panel 2 owns the core; panel 3 pulses a coin with code 3.
  - Response: no `core_coin_valid`; panel 2's coin is forwarded normally.
- **Timeout:**
  - Stimulus: `TIMEOUT`=8; grant with no strobes.
  - Response: `abort` pulses exactly 8 cycles after the grant. `gnt` stays in DRAIN until `core_done`, then releases.
- **Done vs. timeout collision:**
  - Stimulus: `core_done` on the cycle the timer expires.
  - Response: no `abort`; normal RELEASE.
- **Owner withdrawal and reset:**
  - Stimulus: owner drops `req` mid-session, then `rst` is asserted low during DRAIN.
  - Response: `abort` on the cycle after the drop; all outputs 0 immediately on `rst`; after reset release, panel 0 has priority.

Source files
------------

// File: rtl/vend_panel_arbiter_if.sv
// Panel-to-core session bus: per-panel requests and strobes in, owner grant and
// forwarded strobes out toward the vending core.
interface vend_panel_arbiter_if #(
    parameter int unsigned NUM_PANELS = 4,
    parameter int unsigned COIN_W     = 2,
    parameter int unsigned SEL_W      = 2
);
    localparam int unsigned OwnerW = $clog2(NUM_PANELS);

    logic [NUM_PANELS-1:0]        req;
    logic [NUM_PANELS-1:0]        panel_coin_valid;
    logic [NUM_PANELS*COIN_W-1:0] panel_coin;
    logic [NUM_PANELS-1:0]        panel_sel_valid;
    logic [NUM_PANELS*SEL_W-1:0]  panel_sel;
    logic                         core_done;

    logic [NUM_PANELS-1:0]        gnt;
    logic [OwnerW-1:0]            owner;
    logic                         core_coin_valid;
    logic [COIN_W-1:0]            core_coin;
    logic                         core_sel_valid;
    logic [SEL_W-1:0]             core_sel;
    logic                         abort;

    // Panels and core side.
    modport master (
        output req, panel_coin_valid, panel_coin, panel_sel_valid, panel_sel, core_done,
        input  gnt, owner, core_coin_valid, core_coin, core_sel_valid, core_sel, abort
    );

    // Arbiter side.
    modport slave (
        input  req, panel_coin_valid, panel_coin, panel_sel_valid, panel_sel, core_done,
        output gnt, owner, core_coin_valid, core_coin, core_sel_valid, core_sel, abort
    );
endinterface

// File: rtl/vend_panel_arbiter.sv
// Round-robin session arbiter: grants one front panel exclusive use of the vending core
// and forwards only that panel's coin/selection strobes, registered.
module vend_panel_arbiter #(
    parameter int unsigned NUM_PANELS = 4,
    parameter int unsigned COIN_W     = 2,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    vend_panel_arbiter_if.slave bus_io
);

    localparam int unsigned OwnerW = $clog2(NUM_PANELS);
    localparam int unsigned TimerW = $clog2(TIMEOUT);
    localparam logic [TimerW-1:0]     TimerMax = TimerW'(TIMEOUT - 1);
    localparam logic [NUM_PANELS-1:0] GntOne   = NUM_PANELS'(1);

    typedef enum logic [1:0] {StIdle, StActive, StDrain, StRelease} state_e;

    state_e              state_q;
    logic [NUM_PANELS-1:0] gnt_q;
    logic [OwnerW-1:0]   owner_q;
    logic [OwnerW-1:0]   last_owner_q;
    logic [TimerW-1:0]   timer_q;
    logic                core_coin_valid_q;
    logic [COIN_W-1:0]   core_coin_q;
    logic                core_sel_valid_q;
    logic [SEL_W-1:0]    core_sel_q;
    logic                abort_q;

    function automatic logic [OwnerW-1:0] wrap_idx(input logic [OwnerW-1:0] base,
                                                   input int unsigned step);
        return OwnerW'((32'(base) + step) % NUM_PANELS);
    endfunction

    // First requester after the last owner, wrapping.
    logic              pick_found;
    logic [OwnerW-1:0] pick_idx;
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 1; i <= NUM_PANELS; i++) begin
            if (!pick_found && bus_io.req[wrap_idx(last_owner_q, i)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(last_owner_q, i);
            end
        end
    end

    logic              own_req;
    logic              own_coin_valid;
    logic [COIN_W-1:0] own_coin;
    logic              own_sel_valid;
    logic [SEL_W-1:0]  own_sel;
    always_comb begin
        own_req        = 1'b0;
        own_coin_valid = 1'b0;
        own_coin       = '0;
        own_sel_valid  = 1'b0;
        own_sel        = '0;
        for (int unsigned i = 0; i < NUM_PANELS; i++) begin
            if (OwnerW'(i) == owner_q) begin
                own_req        = bus_io.req[i];
                own_coin_valid = bus_io.panel_coin_valid[i];
                own_coin       = bus_io.panel_coin[i*COIN_W +: COIN_W];
                own_sel_valid  = bus_io.panel_sel_valid[i];
                own_sel        = bus_io.panel_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= StIdle;
            gnt_q             <= '0;
            owner_q           <= '0;
            last_owner_q      <= OwnerW'(NUM_PANELS - 1);
            timer_q           <= '0;
            core_coin_valid_q <= 1'b0;
            core_coin_q       <= '0;
            core_sel_valid_q  <= 1'b0;
            core_sel_q        <= '0;
            abort_q           <= 1'b0;
        end else begin
            core_coin_valid_q <= 1'b0;
            core_coin_q       <= '0;
            core_sel_valid_q  <= 1'b0;
            core_sel_q        <= '0;
            abort_q           <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        gnt_q   <= GntOne << pick_idx;
                        owner_q <= pick_idx;
                        timer_q <= '0;
                        state_q <= StActive;
                    end
                end
                StActive: begin
                    // Completion outranks withdrawal/timeout; strobes in either cycle are dropped.
                    if (bus_io.core_done) begin
                        gnt_q   <= '0;
                        state_q <= StRelease;
                    end else if (!own_req || timer_q == TimerMax) begin
                        abort_q <= 1'b1;
                        state_q <= StDrain;
                    end else begin
                        core_coin_valid_q <= own_coin_valid;
                        core_coin_q       <= own_coin_valid ? own_coin : '0;
                        core_sel_valid_q  <= own_sel_valid;
                        core_sel_q        <= own_sel_valid ? own_sel : '0;
                        timer_q <= (own_coin_valid || own_sel_valid) ? '0
                                                                     : timer_q + TimerW'(1);
                    end
                end
                StDrain: begin
                    if (bus_io.core_done) begin
                        gnt_q   <= '0;
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    last_owner_q <= owner_q;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.gnt             = gnt_q;
    assign bus_io.owner           = owner_q;
    assign bus_io.core_coin_valid = core_coin_valid_q;
    assign bus_io.core_coin       = core_coin_q;
    assign bus_io.core_sel_valid  = core_sel_valid_q;
    assign bus_io.core_sel        = core_sel_q;
    assign bus_io.abort           = abort_q;

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Bench for vend_panel_arbiter: directed scenarios plus a randomized run checked
// cycle by cycle against a session-level reference model.
module tb_vend_panel_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned SW = 2;
    localparam int unsigned TO = 8;

    localparam int PhIdle    = 0;
    localparam int PhSession = 1;
    localparam int PhDrain   = 2;
    localparam int PhGuard   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vend_panel_arbiter_if #(.NUM_PANELS(N), .COIN_W(CW), .SEL_W(SW)) bus ();

    vend_panel_arbiter #(
        .NUM_PANELS(N),
        .COIN_W    (CW),
        .SEL_W     (SW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int          m_phase;
    int          m_owner;
    int          m_last;
    int          m_idle;
    logic [N-1:0]  e_gnt;
    logic [1:0]    e_owner;
    logic          e_cv;
    logic [CW-1:0] e_coin;
    logic          e_sv;
    logic [SW-1:0] e_sel;
    logic          e_abort;

    task automatic clear_inputs();
        bus.req              = '0;
        bus.panel_coin_valid = '0;
        bus.panel_coin       = '0;
        bus.panel_sel_valid  = '0;
        bus.panel_sel        = '0;
        bus.core_done        = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        bus.panel_coin_valid = '0;
        bus.panel_sel_valid  = '0;
        bus.core_done        = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic coin(input int p, input int code);
        bus.panel_coin_valid[p]    = 1'b1;
        bus.panel_coin[p*CW +: CW] = CW'(code);
    endtask

    task automatic sel(input int p, input int code);
        bus.panel_sel_valid[p]   = 1'b1;
        bus.panel_sel[p*SW +: SW] = SW'(code);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        vectors++; if (bus.gnt !== 4'b0000) begin miscompares++;
            $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        vectors++; if (bus.owner !== 2'd0) begin miscompares++;
            $display("FAIL reset_owner: got %0d want 0", bus.owner); end
        vectors++; if (bus.core_coin_valid !== 1'b0 || bus.core_coin !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_coin: got v=%b d=%0d want v=0 d=0", bus.core_coin_valid,
                     bus.core_coin); end
        vectors++; if (bus.core_sel_valid !== 1'b0 || bus.core_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_sel: got v=%b d=%0d want v=0 d=0", bus.core_sel_valid,
                     bus.core_sel); end
        vectors++; if (bus.abort !== 1'b0) begin miscompares++;
            $display("FAIL reset_abort: got %b want 0", bus.abort); end
        rst_n = 1'b1;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0000) begin miscompares++;
            $display("FAIL idle_no_req_gnt: got %b want 0000", bus.gnt); end
    endtask

    task automatic test_single_session();
        bus.req = 4'b0010;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin miscompares++;
            $display("FAIL single_grant: got gnt=%b owner=%0d want 0010/1", bus.gnt,
                     bus.owner); end
        next_cycle();
        next_cycle();
        coin(1, 2);
        next_cycle();
        vectors++; if (bus.core_coin_valid !== 1'b1 || bus.core_coin !== 2'd2) begin
            miscompares++;
            $display("FAIL single_coin_fwd: got v=%b d=%0d want v=1 d=2",
                     bus.core_coin_valid, bus.core_coin); end
        next_cycle();
        vectors++; if (bus.core_coin_valid !== 1'b0) begin miscompares++;
            $display("FAIL single_coin_one_shot: got %b want 0", bus.core_coin_valid); end
        sel(1, 1);
        next_cycle();
        vectors++; if (bus.core_sel_valid !== 1'b1 || bus.core_sel !== 2'd1) begin
            miscompares++;
            $display("FAIL single_sel_fwd: got v=%b d=%0d want v=1 d=1",
                     bus.core_sel_valid, bus.core_sel); end
        next_cycle();
        bus.core_done = 1'b1;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0000 || bus.owner !== 2'd1 || bus.abort !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: got gnt=%b owner=%0d abort=%b want 0000/1/0",
                     bus.gnt, bus.owner, bus.abort); end
        bus.req = '0;
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        apply_reset();
        bus.req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            next_cycle();
            exp_g = 4'b0001 << (s % 4);
            vectors++; if (bus.gnt !== exp_g || bus.owner !== 2'(s % 4)) begin miscompares++;
                $display("FAIL rr_grant_%0d: got gnt=%b owner=%0d want %b/%0d", s, bus.gnt,
                         bus.owner, exp_g, s % 4); end
            bus.core_done = 1'b1;
            next_cycle();
            vectors++; if (bus.gnt !== 4'b0000) begin miscompares++;
                $display("FAIL rr_guard_%0d: got %b want 0000", s, bus.gnt); end
            next_cycle();
            vectors++; if (bus.gnt !== 4'b0000) begin miscompares++;
                $display("FAIL rr_idle_%0d: got %b want 0000", s, bus.gnt); end
        end
        bus.req = '0;
        next_cycle();
    endtask

    task automatic test_isolation();
        bus.req = 4'b0100;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2) begin miscompares++;
            $display("FAIL iso_grant: got gnt=%b owner=%0d want 0100/2", bus.gnt, bus.owner); end
        bus.req = 4'b1100;
        coin(3, 3);
        next_cycle();
        vectors++; if (bus.core_coin_valid !== 1'b0) begin miscompares++;
            $display("FAIL iso_foreign_coin: got %b want 0", bus.core_coin_valid); end
        coin(2, 1);
        coin(3, 3);
        next_cycle();
        vectors++; if (bus.core_coin_valid !== 1'b1 || bus.core_coin !== 2'd1) begin
            miscompares++;
            $display("FAIL iso_owner_coin: got v=%b d=%0d want v=1 d=1",
                     bus.core_coin_valid, bus.core_coin); end
        bus.core_done = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        vectors++; if (bus.gnt !== 4'b1000) begin miscompares++;
            $display("FAIL iso_waiting_served: got %b want 1000", bus.gnt); end
        bus.core_done = 1'b1;
        bus.req = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_timeout();
        bus.req = 4'b0001;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0001) begin miscompares++;
            $display("FAIL to_grant: got %b want 0001", bus.gnt); end
        for (int j = 1; j <= 8; j++) begin
            next_cycle();
            vectors++; if (bus.abort !== (j == 8)) begin miscompares++;
                $display("FAIL to_abort_at_%0d: got %b want %b", j, bus.abort, j == 8); end
        end
        coin(0, 2);
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0001 || bus.core_coin_valid !== 1'b0 ||
                       bus.abort !== 1'b0) begin miscompares++;
            $display("FAIL to_drain: got gnt=%b cv=%b abort=%b want 0001/0/0", bus.gnt,
                     bus.core_coin_valid, bus.abort); end
        repeat (12) next_cycle();
        vectors++; if (bus.gnt !== 4'b0001 || bus.abort !== 1'b0) begin miscompares++;
            $display("FAIL to_drain_hold: got gnt=%b abort=%b want 0001/0", bus.gnt,
                     bus.abort); end
        bus.core_done = 1'b1;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0000) begin miscompares++;
            $display("FAIL to_release: got %b want 0000", bus.gnt); end
        bus.req = '0;
        next_cycle();
    endtask

    task automatic test_collision();
        bus.req = 4'b0010;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0010) begin miscompares++;
            $display("FAIL col_grant: got %b want 0010", bus.gnt); end
        repeat (TO - 1) next_cycle();
        bus.core_done = 1'b1;
        coin(1, 3);
        next_cycle();
        vectors++; if (bus.abort !== 1'b0 || bus.gnt !== 4'b0000 ||
                       bus.core_coin_valid !== 1'b0) begin miscompares++;
            $display("FAIL col_done_wins: got abort=%b gnt=%b cv=%b want 0/0000/0",
                     bus.abort, bus.gnt, bus.core_coin_valid); end
        bus.req = '0;
        next_cycle();
        vectors++; if (bus.abort !== 1'b0) begin miscompares++;
            $display("FAIL col_no_late_abort: got %b want 0", bus.abort); end
    endtask

    task automatic test_withdraw_reset();
        bus.req = 4'b0100;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0100) begin miscompares++;
            $display("FAIL wd_grant: got %b want 0100", bus.gnt); end
        coin(2, 2);
        next_cycle();
        vectors++; if (bus.core_coin_valid !== 1'b1 || bus.core_coin !== 2'd2) begin
            miscompares++;
            $display("FAIL wd_coin: got v=%b d=%0d want v=1 d=2", bus.core_coin_valid,
                     bus.core_coin); end
        bus.req = '0;
        next_cycle();
        vectors++; if (bus.abort !== 1'b1 || bus.gnt !== 4'b0100) begin miscompares++;
            $display("FAIL wd_abort: got abort=%b gnt=%b want 1/0100", bus.abort, bus.gnt); end
        next_cycle();
        vectors++; if (bus.abort !== 1'b0 || bus.gnt !== 4'b0100) begin miscompares++;
            $display("FAIL wd_drain: got abort=%b gnt=%b want 0/0100", bus.abort, bus.gnt); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.gnt !== 4'b0000 || bus.owner !== 2'd0 || bus.abort !== 1'b0 ||
                       bus.core_coin_valid !== 1'b0 || bus.core_sel_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_async_reset: got gnt=%b owner=%0d abort=%b cv=%b sv=%b want 0s",
                     bus.gnt, bus.owner, bus.abort, bus.core_coin_valid, bus.core_sel_valid);
        end
        next_cycle();
        rst_n = 1'b1;
        bus.req = 4'b1111;
        next_cycle();
        vectors++; if (bus.gnt !== 4'b0001) begin miscompares++;
            $display("FAIL wd_post_reset_prio: got %b want 0001", bus.gnt); end
        bus.core_done = 1'b1;
        bus.req = '0;
        next_cycle();
        next_cycle();
    endtask

    // Session-level reference: given this cycle's inputs, what the arbiter shows next cycle.
    task automatic model_step();
        e_cv    = 1'b0;
        e_sv    = 1'b0;
        e_abort = 1'b0;
        case (m_phase)
            PhIdle: begin
                if (bus.req != '0) begin
                    int p;
                    p = m_last;
                    do p = (p + 1) % N; while (!bus.req[p]);
                    m_owner = p;
                    e_gnt   = '0;
                    e_gnt[p] = 1'b1;
                    e_owner = 2'(p);
                    m_idle  = 0;
                    m_phase = PhSession;
                end
            end
            PhSession: begin
                if (bus.core_done) begin
                    e_gnt   = '0;
                    m_phase = PhGuard;
                end else if (!bus.req[m_owner] || m_idle == TO - 1) begin
                    e_abort = 1'b1;
                    m_phase = PhDrain;
                end else begin
                    e_cv   = bus.panel_coin_valid[m_owner];
                    e_coin = bus.panel_coin[m_owner*CW +: CW];
                    e_sv   = bus.panel_sel_valid[m_owner];
                    e_sel  = bus.panel_sel[m_owner*SW +: SW];
                    m_idle = (e_cv || e_sv) ? 0 : m_idle + 1;
                end
            end
            PhDrain: begin
                if (bus.core_done) begin
                    e_gnt   = '0;
                    m_phase = PhGuard;
                end
            end
            default: begin
                m_last  = m_owner;
                m_phase = PhIdle;
            end
        endcase
    endtask

    task automatic test_random();
        apply_reset();
        m_phase = PhIdle;
        m_owner = 0;
        m_last  = N - 1;
        m_idle  = 0;
        e_gnt   = '0;
        e_owner = '0;
        e_cv    = 1'b0;
        e_coin  = '0;
        e_sv    = 1'b0;
        e_sel   = '0;
        e_abort = 1'b0;
        for (int c = 0; c < 800; c++) begin
            vectors++; if (bus.gnt !== e_gnt || bus.owner !== e_owner) begin miscompares++;
                $display("FAIL rnd_gnt c=%0d: got gnt=%b owner=%0d want %b/%0d", c, bus.gnt,
                         bus.owner, e_gnt, e_owner); end
            vectors++; if (!$onehot0(bus.gnt)) begin miscompares++;
                $display("FAIL rnd_onehot c=%0d: got %b want one-hot or zero", c, bus.gnt); end
            vectors++; if (bus.abort !== e_abort) begin miscompares++;
                $display("FAIL rnd_abort c=%0d: got %b want %b", c, bus.abort, e_abort); end
            vectors++; if (bus.core_coin_valid !== e_cv ||
                           (e_cv && bus.core_coin !== e_coin)) begin miscompares++;
                $display("FAIL rnd_coin c=%0d: got v=%b d=%0d want v=%b d=%0d", c,
                         bus.core_coin_valid, bus.core_coin, e_cv, e_coin); end
            vectors++; if (bus.core_sel_valid !== e_sv ||
                           (e_sv && bus.core_sel !== e_sel)) begin miscompares++;
                $display("FAIL rnd_sel c=%0d: got v=%b d=%0d want v=%b d=%0d", c,
                         bus.core_sel_valid, bus.core_sel, e_sv, e_sel); end
            for (int p = 0; p < N; p++) begin
                if ((m_phase == PhSession || m_phase == PhDrain) && p == m_owner) begin
                    if ($urandom_range(0, 47) == 0) bus.req[p] = 1'b0;
                end else if (m_phase == PhGuard && p == m_owner) begin
                    if ($urandom_range(0, 1) == 0) bus.req[p] = 1'b0;
                end else if (!bus.req[p]) begin
                    bus.req[p] = ($urandom_range(0, 5) == 0);
                end
                bus.panel_coin_valid[p]   = ($urandom_range(0, 5) == 0);
                bus.panel_coin[p*CW +: CW] = CW'($urandom);
                bus.panel_sel_valid[p]    = ($urandom_range(0, 6) == 0);
                bus.panel_sel[p*SW +: SW]  = SW'($urandom);
            end
            bus.core_done = ($urandom_range(0, 13) == 0);
            model_step();
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_session();
        test_round_robin();
        test_isolation();
        test_timeout();
        test_collision();
        test_withdraw_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1);
    end

endmodule
